// File: rtl/batch_summer.sv
// Batch accumulator: sums BATCH unsigned numbers (or fewer on flush) and offers
// each sum with its item count downstream over a valid/ready handshake.
module batch_summer #(
  parameter int WIDTH     = 5,
  parameter int BATCH     = 4,
  parameter int SUM_WIDTH = WIDTH + $clog2(BATCH),
  parameter int CNT_WIDTH = $clog2(BATCH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prev_valid,
  output logic                 this_ready,
  input  logic [WIDTH-1:0]     input_num,
  input  logic                 flush,
  output logic                 this_valid,
  input  logic                 next_ready,
  output logic [SUM_WIDTH-1:0] output_num,
  output logic [CNT_WIDTH-1:0] output_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [SUM_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [SUM_WIDTH-1:0]   out_num_reg, out_num_next;
  logic [CNT_WIDTH-1:0]   out_cnt_reg, out_cnt_next;

  logic [SUM_WIDTH-1:0]   acc_sum;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   in_xfer;
  logic                   out_xfer;

  // Ready depends on state and reset only, so no combinational path from next_ready.
  assign this_ready   = (state_reg == ACCUM) && reset;
  assign this_valid   = (state_reg == EMIT);
  assign output_num   = out_num_reg;
  assign output_count = out_cnt_reg;

  assign in_xfer  = prev_valid && this_ready;
  assign out_xfer = this_valid && next_ready;
  assign acc_sum  = acc_reg + SUM_WIDTH'(input_num);
  assign cnt_inc  = cnt_reg + CNT_WIDTH'(1);

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    out_num_next = out_num_reg;
    out_cnt_next = out_cnt_reg;
    unique case (state_reg)
      ACCUM: begin
        if (in_xfer) begin
          acc_next = acc_sum;
          cnt_next = cnt_inc;
          if ((cnt_inc == CNT_WIDTH'(BATCH)) || flush) begin
            state_next   = EMIT;
            out_num_next = acc_sum;
            out_cnt_next = cnt_inc;
          end
        end else if (flush && (cnt_reg != '0)) begin
          // An empty batch is never emitted; flush only closes a non-empty one.
          state_next   = EMIT;
          out_num_next = acc_reg;
          out_cnt_next = cnt_reg;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ACCUM;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      out_num_reg <= '0;
      out_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      out_num_reg <= out_num_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

endmodule

// File: doc/batch_summer.md
# batch_summer

Downstream consumer stage for the adder/delayer number pipeline. It accepts a stream of numbers over the standard prev_valid/this_ready handshake and accumulates them into a running sum. It emits one sum per batch of BATCH items, or a partial batch on `flush`. The result is offered downstream over the same handshake and held stable under backpressure.

## Interface

- `WIDTH`, default 5: input number width (matches pipeline stage width).
- `BATCH`, default 4: items per full batch; legal range ≥ 2.
- `SUM_WIDTH`, default `WIDTH + $clog2(BATCH)`: accumulator/output width; derived, never overridden.
- `CNT_WIDTH`, default `$clog2(BATCH+1)`: item-count width; derived.

Ports:

- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = in reset).
- `prev_valid`  input  1  upstream has a number on `input_num`.
- `this_ready`  output  1  this stage accepts a number this cycle.
- `input_num`  input  WIDTH  number from upstream stage.
- `flush`  input  1  close the current batch early (sampled only in ACCUM).
- `this_valid`  output  1  `output_num`/`output_count` hold a completed sum.
- `next_ready`  input  1  downstream accepts the sum this cycle.
- `output_num`  output  SUM_WIDTH  batch sum, unsigned.
- `output_count`  output  CNT_WIDTH  number of items summed into `output_num` (1..BATCH).

## Operation

- Transfer in: `prev_valid && this_ready` at a rising edge. Transfer out: `this_valid && next_ready` at a rising edge.
- State machine, two states:
  - ACCUM: `this_ready = 1`, `this_valid = 0`.
    - On input transfer: `acc <= acc + input_num` (zero-extended), `cnt <= cnt + 1`.
    - If the new count equals BATCH, or `flush` is high in the same cycle, go to EMIT. Load `output_num` with the new sum and `output_count` with the new count.
    - `flush` with no transfer and `cnt > 0`: go to EMIT with the current `acc`/`cnt`.
    - `flush` with no transfer and `cnt == 0`: ignored; stay in ACCUM.
  - EMIT: `this_ready = 0`, `this_valid = 1`. `output_num`/`output_count` are held constant. `flush` and `input_num` are ignored.
    - On output transfer: `acc <= 0`, `cnt <= 0`, go to ACCUM.
- Arithmetic: unsigned; SUM_WIDTH is sized so that BATCH × (2^WIDTH − 1) never overflows. Default maximum is 4 × 31 = 124, which fits in 7 bits.
- `this_ready` is a decode of state only (no combinational path from `next_ready` or `prev_valid`). `this_ready` is forced to 0 while `reset == 0`.
- Reset (`reset == 0` at an edge), from any state, mid-batch or mid-emit:
  - state ← ACCUM, `acc` ← 0, `cnt` ← 0.
  - `this_valid` ← 0, `output_num` ← 0, `output_count` ← 0.
  - The partial batch is discarded and no sum is emitted for it.

## Timing

- Input accepted at edge N completes a batch → `this_valid` is high from the cycle after edge N. Latency is 1 cycle.
- `this_ready` is low for every cycle `this_valid` is high. It returns high in the cycle after the output transfer edge.
- Minimum batch period is BATCH + 1 cycles (BATCH input transfers + 1 emit cycle with `next_ready` held high).
- While `this_valid && !next_ready`, `output_num` and `output_count` are bit-stable every cycle. `this_valid` never drops without a transfer, except on reset.
- After `reset` returns to 1, the first input transfer can occur at the next edge.

## Test plan

- Full batch: feed 1, 2, 3, 4 on back-to-back cycles with `next_ready = 1`.
  - `this_valid` rises one cycle after the 4th transfer, with `output_num = 10` and `output_count = 4`, for exactly 1 cycle.
  - `this_ready` is low during that cycle and high again on the next.
- Backpressure: feed 31, 31, 31, 31 with `next_ready = 0` for 3 cycles after the sum appears.
  - `output_num = 124` and `output_count = 4` are held for all 4 cycles.
  - `this_ready = 0` throughout; `prev_valid` held high does not change `acc`.
  - Transfer occurs when `next_ready` rises.
- Flush paths:
  - Feed 7, 9, then `flush` alone → `output_num = 16`, `output_count = 2`.
  - Feed 5, 6, then 8 with `flush` in the same cycle → `output_num = 19`, `output_count = 3`.
  - `flush` with `cnt == 0` → no `this_valid`, state stays ACCUM.
- Reset mid-operation:
  - Feed 3, 3, then pull `reset` low for 1 cycle, then feed 1, 2, 3, 4 → `output_num = 10` (not 16).
  - Reset asserted during EMIT → `this_valid = 0` and `output_num = 0` on the next cycle.
- Bubbles and parameters:
  - With `prev_valid` toggling 1/0 and inputs 2, 4, 6, 8 → `output_num = 20`, `output_count = 4`.
  - Repeat with BATCH = 3: inputs 31, 31, 31 → `output_num = 93`, `output_count = 3`.
